// File: rtl/pwm_cap_pkg.sv
// Shared types and defaults for the PWM capture block.
// The state type is shared with other capture-style front ends.
package pwm_cap_pkg;

  localparam int W_DEF   = 11;
  localparam int TMO_DEF = 4096;
  localparam int CNT_MAX = (1 << W_DEF) - 1;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer plus an edge-detect flop for one asynchronous input.
// The data flops carry no reset, so a reset never manufactures a false edge on a held input.
module sync_edge (
  input  logic clk,
  input  logic async_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_d;
  logic [2:0] sync_q;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign lvl  = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input,
// reporting one pair per complete period and flagging a stuck input.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] period_cnt,
  output logic         meas_vld,
  output logic         ovf,
  output logic         stuck,
  output logic         stuck_lvl
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [W-1:0]  MAX_V = {W{1'b1}};
  localparam logic [W-1:0]  ONE_V = W'(1);
  localparam logic [TW-1:0] TMO_V = TW'(TMO);

  logic lvl, rise, fall, any_edge;

  cap_state_t    state_d, state_q;
  logic [W-1:0]  hcnt_d, hcnt_q;
  logic [W-1:0]  pcnt_d, pcnt_q;
  logic [TW-1:0] tcnt_d, tcnt_q;
  logic [W-1:0]  high_cnt_d, high_cnt_q;
  logic [W-1:0]  period_cnt_d, period_cnt_q;
  logic          vld_d, vld_q;
  logic          ovf_d, ovf_q;
  logic          stuck_d, stuck_q;
  logic          stuck_lvl_d, stuck_lvl_q;

  sync_edge u_sync (
    .clk      (clk),
    .async_in (pwm_in),
    .lvl      (lvl),
    .rise     (rise),
    .fall     (fall)
  );

  assign any_edge = rise | fall;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    pcnt_d       = pcnt_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    vld_d        = 1'b0;
    ovf_d        = ovf_q;
    stuck_d      = stuck_q;
    stuck_lvl_d  = stuck_lvl_q;

    if (any_edge) begin
      tcnt_d = '0;
    end else if (tcnt_q == TMO_V) begin
      tcnt_d = tcnt_q;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end

    // A rise seen in HIGH cannot come out of the edge detector, but is closed like a LOW rise.
    case (state_q)
      ARM: begin
        if (rise) begin
          state_d     = HIGH;
          hcnt_d      = ONE_V;
          pcnt_d      = ONE_V;
          stuck_d     = 1'b0;
          stuck_lvl_d = 1'b0;
        end
      end
      HIGH, LOW: begin
        if (rise) begin
          high_cnt_d   = hcnt_q;
          period_cnt_d = pcnt_q;
          ovf_d        = (pcnt_q == MAX_V);
          vld_d        = 1'b1;
          hcnt_d       = ONE_V;
          pcnt_d       = ONE_V;
          state_d      = HIGH;
        end else begin
          pcnt_d = (pcnt_q == MAX_V) ? pcnt_q : pcnt_q + 1'b1;
          if (state_q == HIGH) begin
            if (fall) begin
              state_d = LOW;
            end else begin
              hcnt_d = (hcnt_q == MAX_V) ? hcnt_q : hcnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ARM;
    endcase

    // The timeout only fires on a cycle with no edge, so a coincident edge always wins.
    if (!any_edge && (tcnt_q != TMO_V) && (tcnt_d == TMO_V)) begin
      stuck_d     = 1'b1;
      stuck_lvl_d = lvl;
      state_d     = ARM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARM;
      hcnt_q       <= '0;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      vld_q        <= 1'b0;
      ovf_q        <= 1'b0;
      stuck_q      <= 1'b0;
      stuck_lvl_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      vld_q        <= vld_d;
      ovf_q        <= ovf_d;
      stuck_q      <= stuck_d;
      stuck_lvl_q  <= stuck_lvl_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_vld   = vld_q;
  assign ovf        = ovf_q;
  assign stuck      = stuck_q;
  assign stuck_lvl  = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a waveform-level model predicts each report
// from edge timestamps; a monitor pops and compares on every meas_vld.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  localparam int W    = 11;
  localparam int TMO  = 4096;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         meas_vld;
  logic         ovf;
  logic         stuck;
  logic         stuck_lvl;

  pwm_capture #(.W(W), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_vld   (meas_vld),
    .ovf        (ovf),
    .stuck      (stuck),
    .stuck_lvl  (stuck_lvl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int h;
    int p;
    int o;
  } meas_t;

  meas_t expQ[$];
  meas_t lastMeas = '{0, 0, 0};
  int    nAssert = 0;
  int    nFail = 0;
  bit    armed = 1'b0;
  int    riseT = 0;
  int    fallT = 0;
  int    lastEdgeT = 0;
  bit    prevVld = 1'b0;
  bit    stuckSeen = 1'b0;

  function automatic int sat(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    nAssert++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a pin edge at clock index t. Silence longer than TMO means the
  // capture went stuck and re-armed, so that rise starts a fresh, unreported period.
  task automatic modelEdge(bit lvl, int t);
    meas_t m;
    if (t - lastEdgeT > TMO) armed = 1'b0;
    if (lvl) begin
      if (armed) begin
        m.h = sat(fallT - riseT);
        m.p = sat(t - riseT);
        m.o = ((t - riseT) >= MAXC) ? 1 : 0;
        expQ.push_back(m);
        lastMeas = m;
      end
      armed = 1'b1;
      riseT = t;
    end else begin
      fallT = t;
    end
    lastEdgeT = t;
  endtask

  // Entered just after a negedge; the new level is first sampled at posedge cyc+1.
  task automatic applyStimulus(bit lvl, int n);
    if (lvl != pwm_in) begin
      pwm_in = lvl;
      modelEdge(lvl, cyc + 1);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_high"},   int'(high_cnt),   0);
    checkOutput({tag, "_period"}, int'(period_cnt), 0);
    checkOutput({tag, "_vld"},    int'(meas_vld),   0);
    checkOutput({tag, "_ovf"},    int'(ovf),        0);
    checkOutput({tag, "_stuck"},  int'(stuck),      0);
    checkOutput({tag, "_lvl"},    int'(stuck_lvl),  0);
  endtask

  always @(negedge clk) begin
    if (meas_vld) begin
      checkOutput("vld_one_cycle", int'(prevVld), 0);
      if (expQ.size() == 0) begin
        nAssert++;
        nFail++;
        $display("[TB] FAIL unexpected_vld: got high=%0d period=%0d, expected no report", high_cnt, period_cnt);
      end else begin
        meas_t e;
        e = expQ.pop_front();
        checkOutput("high_cnt",   int'(high_cnt),   e.h);
        checkOutput("period_cnt", int'(period_cnt), e.p);
        checkOutput("ovf",        int'(ovf),        e.o);
      end
    end
    prevVld = meas_vld;
    if (stuck) stuckSeen = 1'b1;
  end

  initial begin
    int p;
    int h;
    int holdT;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    lastEdgeT = cyc;
    applyStimulus(0, 100);
    checkAllZero("idle");

    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(1800, 2);
      h = $urandom_range(p - 1, 1);
      applyStimulus(1, h);
      applyStimulus(0, p - h);
    end

    applyStimulus(1, 2045); applyStimulus(0, 1);
    applyStimulus(1, 1);    applyStimulus(0, 2046);
    applyStimulus(1, 500);  applyStimulus(0, 2500);
    applyStimulus(1, 2500); applyStimulus(0, 100);

    // Generator loopback, duty 0x400 over a 2048-cycle frame.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 2048; k++) begin
        applyStimulus(k < 11'h400, 1);
      end
    end

    // Low for exactly TMO cycles: the closing rise coincides with the timeout.
    applyStimulus(1, 300);
    stuckSeen = 1'b0;
    applyStimulus(0, TMO);
    applyStimulus(1, 300);
    checkOutput("tie_no_stuck", int'(stuckSeen), 0);
    applyStimulus(0, 400);

    // Hold high after a valid period until the input is declared stuck.
    applyStimulus(1, TMO + 2);
    checkOutput("stuck_early", int'(stuck), 0);
    applyStimulus(1, 1);
    checkOutput("stuck_set",     int'(stuck),      1);
    checkOutput("stuck_lvl",     int'(stuck_lvl),  1);
    checkOutput("held_high",     int'(high_cnt),   lastMeas.h);
    checkOutput("held_period",   int'(period_cnt), lastMeas.p);
    holdT = 5000 - TMO - 3;
    applyStimulus(1, holdT);

    // Resume a 200/800 waveform; the fall is ignored and the first rise clears stuck.
    applyStimulus(0, 600);
    checkOutput("stuck_thru_fall", int'(stuck), 1);
    applyStimulus(1, 2);
    checkOutput("stuck_pre_rise", int'(stuck), 1);
    applyStimulus(1, 1);
    checkOutput("stuck_cleared", int'(stuck), 0);
    applyStimulus(1, 197);
    applyStimulus(0, 600);
    applyStimulus(1, 200);
    applyStimulus(0, 600);
    applyStimulus(1, 100);

    // One-cycle reset in the middle of a high phase.
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midrst");
    rst = 1'b0;
    armed = 1'b0;
    lastEdgeT = cyc;
    applyStimulus(1, 100);
    applyStimulus(0, 300);
    applyStimulus(1, 150);
    applyStimulus(0, 350);
    applyStimulus(1, 50);
    applyStimulus(0, 20);

    repeat (10) @(negedge clk);
    checkOutput("pending_reports", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
